// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sequencer sharing one 16-bit ALU between two requesters
module alu_share_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0_valid,
    input  logic        i_req1_valid,
    output logic        o_req0_ready,
    output logic        o_req1_ready,
    input  logic [15:0] i_req0_a,
    input  logic [15:0] i_req0_b,
    input  logic [15:0] i_req1_a,
    input  logic [15:0] i_req1_b,
    input  logic [2:0]  i_req0_ctrl,
    input  logic [2:0]  i_req1_ctrl,
    output logic        o_rsp0_valid,
    output logic        o_rsp1_valid,
    input  logic        i_rsp0_ready,
    input  logic        i_rsp1_ready,
    output logic [15:0] o_rsp_result,
    output logic [15:0] o_rsp_hi,
    output logic        o_rsp_err,
    output logic [15:0] o_alu_a,
    output logic [15:0] o_alu_b,
    output logic [2:0]  o_alu_ctrl,
    input  logic [15:0] i_alu_result,
    input  logic [15:0] i_alu_overflow,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [3:0] LAT    = 4'(MULDIV_LAT);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_last_grant;
    logic        r_owner;
    logic [3:0]  r_cnt;
    logic        r_dbz;
    logic [15:0] r_dbz_a;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic [2:0]  r_alu_ctrl;
    logic [15:0] r_rsp_result;
    logic [15:0] r_rsp_hi;
    logic        r_rsp_err;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_accept;
    logic        w_capture;
    logic [15:0] w_sel_a;
    logic [15:0] w_sel_b;
    logic [2:0]  w_sel_ctrl;
    logic        w_sel_dbz;
    logic        w_sel_muldiv;
    logic [3:0]  w_sel_lat;
    logic        w_cur_muldiv;

    // On a tie the requester that did not win last time is granted.
    assign w_gnt0 = i_req0_valid & (~i_req1_valid | r_last_grant);
    assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);

    assign w_sel_a      = w_gnt1 ? i_req1_a    : i_req0_a;
    assign w_sel_b      = w_gnt1 ? i_req1_b    : i_req0_b;
    assign w_sel_ctrl   = w_gnt1 ? i_req1_ctrl : i_req0_ctrl;
    assign w_sel_dbz    = (w_sel_ctrl == OP_DIV) && (w_sel_b == 16'h0000);
    assign w_sel_muldiv = (w_sel_ctrl == OP_MUL) || (w_sel_ctrl == OP_DIV);
    assign w_sel_lat    = (w_sel_muldiv && !w_sel_dbz) ? LAT : 4'd1;
    assign w_cur_muldiv = (r_alu_ctrl == OP_MUL) || (r_alu_ctrl == OP_DIV);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        o_req0_ready = 1'b0;
        o_req1_ready = 1'b0;
        o_rsp0_valid = 1'b0;
        o_rsp1_valid = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req0_ready = w_gnt0;
                o_req1_ready = w_gnt1;
                w_accept     = w_gnt0 | w_gnt1;
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == 4'd1) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_rsp0_valid = ~r_owner;
                o_rsp1_valid = r_owner;
                if (r_owner ? i_rsp1_ready : i_rsp0_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= 4'd0;
            r_dbz        <= 1'b0;
            r_dbz_a      <= 16'h0000;
            r_alu_a      <= 16'h0000;
            r_alu_b      <= 16'h0000;
            r_alu_ctrl   <= 3'b000;
            r_rsp_result <= 16'h0000;
            r_rsp_hi     <= 16'h0000;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_gnt1;
                r_last_grant <= w_gnt1;
                r_cnt        <= w_sel_lat;
                r_dbz        <= w_sel_dbz;
                r_dbz_a      <= w_sel_a;
                // A zero divisor never reaches the ALU; the previous operands stay put.
                if (!w_sel_dbz) begin
                    r_alu_a    <= w_sel_a;
                    r_alu_b    <= w_sel_b;
                    r_alu_ctrl <= w_sel_ctrl;
                end
            end else if ((r_state == S_EXEC) && (r_cnt != 4'd1)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_capture) begin
                if (r_dbz) begin
                    r_rsp_result <= 16'hFFFF;
                    r_rsp_hi     <= r_dbz_a;
                    r_rsp_err    <= 1'b1;
                end else begin
                    r_rsp_result <= i_alu_result;
                    r_rsp_hi     <= w_cur_muldiv ? i_alu_overflow : 16'h0000;
                    r_rsp_err    <= 1'b0;
                end
            end
        end
    end

    assign o_alu_a      = r_alu_a;
    assign o_alu_b      = r_alu_b;
    assign o_alu_ctrl   = r_alu_ctrl;
    assign o_rsp_result = r_rsp_result;
    assign o_rsp_hi     = r_rsp_hi;
    assign o_rsp_err    = r_rsp_err;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - self-checking bench for alu_share_ctrl with a transaction-level model
module tb_alu_share_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [15:0] rsp_result, rsp_hi;
    logic        rsp_err;
    logic [15:0] alu_a, alu_b, alu_result, alu_overflow;
    logic [2:0]  alu_ctrl;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.MULDIV_LAT(LAT)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
        .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
        .i_req0_a(req0_a), .i_req0_b(req0_b), .i_req1_a(req1_a), .i_req1_b(req1_b),
        .i_req0_ctrl(req0_ctrl), .i_req1_ctrl(req1_ctrl),
        .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
        .i_rsp0_ready(rsp0_ready), .i_rsp1_ready(rsp1_ready),
        .o_rsp_result(rsp_result), .o_rsp_hi(rsp_hi), .o_rsp_err(rsp_err),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_ctrl(alu_ctrl),
        .i_alu_result(alu_result), .i_alu_overflow(alu_overflow),
        .o_busy(busy)
    );

    // Shared ALU; hi carries junk on non-mul/div ops so masking is observable.
    logic [31:0] alu_prod;
    logic [16:0] alu_sum;
    always_comb begin
        alu_prod     = 32'(alu_a) * 32'(alu_b);
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result   = 16'h0000;
        alu_overflow = 16'h0000;
        case (alu_ctrl)
            3'b000: begin alu_result = alu_sum[15:0]; alu_overflow = {15'b0, alu_sum[16]}; end
            3'b001: begin alu_result = alu_a - alu_b; alu_overflow = 16'h5A5A; end
            3'b010: {alu_overflow, alu_result} = alu_prod;
            3'b011: begin
                if (alu_b != 16'h0000) begin
                    alu_result = alu_a / alu_b; alu_overflow = alu_a % alu_b;
                end else begin
                    alu_result = 16'hDEAD; alu_overflow = 16'hBEEF;
                end
            end
            3'b100: begin alu_result = alu_a & alu_b; alu_overflow = 16'h1111; end
            3'b101: begin alu_result = alu_a | alu_b; alu_overflow = 16'h2222; end
            default: begin alu_result = 16'h0000; alu_overflow = 16'h0000; end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Returns {err, hi, result} for one request from plain arithmetic.
    function automatic logic [32:0] spec_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned p;
        logic [15:0] res = 16'h0000;
        logic [15:0] hi  = 16'h0000;
        logic        err = 1'b0;
        case (c)
            3'b000: res = 16'((ua + ub) % 65536);
            3'b001: res = 16'((ua + 65536 - ub) % 65536);
            3'b010: begin p = ua * ub; res = 16'(p % 65536); hi = 16'(p / 65536); end
            3'b011: begin
                if (ub == 0) begin res = 16'hFFFF; hi = a; err = 1'b1; end
                else begin res = 16'(ua / ub); hi = 16'(ua % ub); end
            end
            3'b100: res = a & b;
            3'b101: res = a | b;
            default: res = 16'h0000;
        endcase
        return {err, hi, res};
    endfunction

    function automatic int pick(input logic v0, input logic v1, input int last);
        if (v0 && v1) return (last == 1) ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    // Transaction model: idle/busy, owner, cycle the response becomes visible.
    bit          m_live = 0;
    bit          m_busy;
    int          m_owner, m_last, m_rsp_at, cyc = 0;
    logic [15:0] m_a, m_b, m_res, m_hi;
    logic [2:0]  m_ctrl;
    logic        m_err;
    logic [32:0] m_pend;

    always @(posedge clk) begin
        int g;
        if (reset) begin
            m_live = 1; m_busy = 0; m_last = 1; m_owner = 0;
            m_a = 0; m_b = 0; m_ctrl = 0; m_res = 0; m_hi = 0; m_err = 0;
        end else if (m_live) begin
            if (!m_busy) begin
                g = pick(req0_valid, req1_valid, m_last);
                if (g >= 0) begin
                    logic [15:0] a, b;
                    logic [2:0]  c;
                    a = (g == 1) ? req1_a : req0_a;
                    b = (g == 1) ? req1_b : req0_b;
                    c = (g == 1) ? req1_ctrl : req0_ctrl;
                    m_pend   = spec_op(c, a, b);
                    m_rsp_at = cyc + 1 + (((c == 3'b010) || (c == 3'b011 && b != 0)) ? LAT : 1);
                    if (!(c == 3'b011 && b == 0)) begin m_a = a; m_b = b; m_ctrl = c; end
                    m_owner = g; m_last = g; m_busy = 1;
                end
            end else if (cyc >= m_rsp_at && ((m_owner == 1) ? rsp1_ready : rsp0_ready)) begin
                m_busy = 0;
            end
        end
        cyc++;
        if (m_busy && cyc == m_rsp_at) {m_err, m_hi, m_res} = m_pend;
    end

    always @(negedge clk) begin
        if (m_live) begin
            int  g;
            bit  v;
            g = m_busy ? -1 : pick(req0_valid, req1_valid, m_last);
            v = m_busy && (cyc >= m_rsp_at);
            check("m_req0_ready", req0_ready, g == 0);
            check("m_req1_ready", req1_ready, g == 1);
            check("m_rsp0_valid", rsp0_valid, v && m_owner == 0);
            check("m_rsp1_valid", rsp1_valid, v && m_owner == 1);
            check("m_busy", busy, m_busy);
            check("m_rsp_result", rsp_result, m_res);
            check("m_rsp_hi", rsp_hi, m_hi);
            check("m_rsp_err", rsp_err, m_err);
            check("m_alu_a", alu_a, m_a);
            check("m_alu_b", alu_b, m_b);
            check("m_alu_ctrl", alu_ctrl, m_ctrl);
            check("m_no_div0_on_alu", (alu_ctrl == 3'b011) && (alu_b == 0), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
        if (p == 0) begin req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b; end
        else        begin req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b; end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic run_op(input int p, input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                          input int exp_lat, input logic [15:0] e_res, input logic [15:0] e_hi, input logic e_err);
        int n;
        int lat;
        set_req(p, 1'b1, c, a, b);
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin tick(); n++; end
        check("op_ready_seen", rdy(p), 1'b1);
        tick();
        set_req(p, 1'b0, 3'b000, 16'h0, 16'h0);
        lat = 1;
        while (!rspv(p) && lat < 40) begin tick(); lat++; end
        check("op_latency", lat, exp_lat);
        check("op_result", rsp_result, e_res);
        check("op_hi", rsp_hi, e_hi);
        check("op_err", rsp_err, e_err);
        if (p == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check("op_idle_after", busy, 1'b0);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int          i0, i1, nrsp, nrsp1, ng, n;
        int          gorder[8];
        logic [2:0]  c0[2], c1[2];
        logic [15:0] a0[2], b0[2], a1[2], b1[2];

        reset = 1'b1;
        set_req(0, 1'b0, 3'b000, 16'h0, 16'h0);
        set_req(1, 1'b0, 3'b000, 16'h0, 16'h0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valids", {rsp0_valid, rsp1_valid}, 2'b00);
        check("rst_rsp_fields", {rsp_result, rsp_hi, rsp_err}, 33'h0);
        check("rst_alu", {alu_a, alu_b, alu_ctrl}, 35'h0);
        reset = 1'b0;

        run_op(0, 3'b000, 16'hFFFF, 16'h0002, 2, 16'h0001, 16'h0000, 1'b0);
        run_op(1, 3'b010, 16'h1234, 16'h0100, 1 + LAT, 16'h3400, 16'h0012, 1'b0);
        run_op(0, 3'b011, 16'h00AB, 16'h0000, 2, 16'hFFFF, 16'h00AB, 1'b1);
        check("dbz_alu_b_kept", alu_b, 16'h0100);
        check("dbz_alu_ctrl_kept", alu_ctrl, 3'b010);
        run_op(1, 3'b001, 16'h0000, 16'h0001, 2, 16'hFFFF, 16'h0000, 1'b0);
        run_op(0, 3'b111, 16'h0005, 16'h0006, 2, 16'h0000, 16'h0000, 1'b0);
        run_op(1, 3'b100, 16'hF0F0, 16'h3C3C, 2, 16'h3030, 16'h0000, 1'b0);

        // Contention: both requesters valid from reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c0[0] = 3'b100; a0[0] = 16'h00FF; b0[0] = 16'h0F0F;
        c0[1] = 3'b101; a0[1] = 16'h00F0; b0[1] = 16'h000F;
        c1[0] = 3'b011; a1[0] = 16'd100;  b1[0] = 16'd7;
        c1[1] = 3'b010; a1[1] = 16'd3;    b1[1] = 16'd5;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        i0 = 0; i1 = 0; nrsp = 0; nrsp1 = 0; ng = 0;
        for (int c = 0; c < 100 && nrsp < 4; c++) begin
            set_req(0, i0 < 2, c0[i0 < 2 ? i0 : 1], a0[i0 < 2 ? i0 : 1], b0[i0 < 2 ? i0 : 1]);
            set_req(1, i1 < 2, c1[i1 < 2 ? i1 : 1], a1[i1 < 2 ? i1 : 1], b1[i1 < 2 ? i1 : 1]);
            #1;
            check("tie_never_both_ready", req0_ready & req1_ready, 1'b0);
            if (req0_ready && ng < 8) begin gorder[ng] = 0; ng++; i0++; end
            if (req1_ready && ng < 8) begin gorder[ng] = 1; ng++; i1++; end
            if (rsp0_valid) nrsp++;
            if (rsp1_valid) begin
                if (nrsp1 == 0) begin
                    check("div_100_7_result", rsp_result, 16'd14);
                    check("div_100_7_hi", rsp_hi, 16'd2);
                end
                nrsp++;
                nrsp1++;
            end
            tick();
        end
        check("tie_responses", nrsp, 4);
        check("tie_grants", ng, 4);
        check("tie_served0", i0, 2);
        check("tie_served1", i1, 2);
        for (int k = 0; k < 4 && k < ng; k++) check("tie_grant_order", gorder[k], k % 2);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        // Backpressure on rsp0 with req1 waiting and rsp1_ready asserted.
        set_req(0, 1'b1, 3'b000, 16'h1000, 16'h0234);
        set_req(1, 1'b1, 3'b001, 16'h0005, 16'h0003);
        rsp1_ready = 1'b1;
        #1;
        check("bp_grant0", {req0_ready, req1_ready}, 2'b10);
        tick();
        set_req(0, 1'b0, 3'b000, 16'h0, 16'h0);
        n = 0;
        while (!rsp0_valid && n < 20) begin tick(); n++; end
        check("bp_rsp_seen", rsp0_valid, 1'b1);
        for (int k = 0; k < 10; k++) begin
            check("bp_result", rsp_result, 16'h1234);
            check("bp_valid", {rsp0_valid, rsp1_valid}, 2'b10);
            check("bp_busy", busy, 1'b1);
            check("bp_no_accept", req1_ready, 1'b0);
            tick();
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        check("bp_idle_after", busy, 1'b0);
        check("bp_req1_now", req1_ready, 1'b1);
        tick();
        set_req(1, 1'b0, 3'b000, 16'h0, 16'h0);
        n = 0;
        while (!rsp1_valid && n < 20) begin tick(); n++; end
        check("bp_req1_result", rsp_result, 16'h0002);
        tick();
        rsp1_ready = 1'b0;

        // Reset in the middle of a req0 multiply.
        set_req(0, 1'b1, 3'b010, 16'h0003, 16'h0004);
        #1;
        check("mx_ready0", req0_ready, 1'b1);
        tick();
        set_req(0, 1'b0, 3'b000, 16'h0, 16'h0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mx_busy", busy, 1'b0);
        check("mx_valids", {rsp0_valid, rsp1_valid}, 2'b00);
        check("mx_rsp_fields", {rsp_result, rsp_hi, rsp_err}, 33'h0);
        check("mx_alu", {alu_a, alu_b, alu_ctrl}, 35'h0);
        set_req(0, 1'b1, 3'b000, 16'h0001, 16'h0001);
        set_req(1, 1'b1, 3'b000, 16'h0002, 16'h0002);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #1;
        check("mx_tie_grant", {req0_ready, req1_ready}, 2'b10);
        tick();
        set_req(0, 1'b0, 3'b000, 16'h0, 16'h0);
        n = 0;
        while (!req1_ready && n < 20) begin tick(); n++; end
        tick();
        set_req(1, 1'b0, 3'b000, 16'h0, 16'h0);
        n = 0;
        while (!rsp1_valid && n < 20) begin tick(); n++; end
        check("mx_req1_result", rsp_result, 16'h0004);
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-port sequencing controller that shares the single 16-bit combinational ALU between two requesters, such as the decode/execute path and a debug/DMA port. It arbitrates round-robin and holds registered operands stable on the ALU for a per-opcode settle time. It captures result and high word (multiply high half / divide remainder) and returns them over a valid/ready response channel. It also intercepts divide-by-zero so the ALU is never evaluated with B = 0 on a divide.

## Interface

- `MULDIV_LAT`, default 4: EXEC cycles for opcodes 3'b010 (mul) and 3'b011 (div); legal range 1–15.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1 each  request present.
- `req0_ready`, `req1_ready`  out  1 each  request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  16 each  operands.
- `req0_ctrl`, `req1_ctrl`  in  3 each  ALU opcode: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110/111 zero.
- `rsp0_valid`, `rsp1_valid`  out  1 each  response available.
- `rsp0_ready`, `rsp1_ready`  in  1 each  response consumed.
- `rsp_result`  out  16  low result word, shared by both response ports.
- `rsp_hi`  out  16  high word.
- `rsp_err`  out  1  divide-by-zero flag.
- `alu_a`, `alu_b`  out  16 each  registered ALU operands.
- `alu_ctrl`  out  3  registered ALU opcode.
- `alu_result`, `alu_overflow`  in  16 each  ALU outputs.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation

- **FSM states:** IDLE, EXEC, DONE. Reset → IDLE.
- **Arbitration** (IDLE only):
  - If exactly one `reqN_valid` is high, grant it.
  - If both are high, grant the requester not in `last_grant`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `reqN_ready` is combinational: (state == IDLE) & `reqN_valid` & granted. At most one ready is high per cycle. Ready is never high outside IDLE.
- **Accept** (`reqN_valid` & `reqN_ready`):
  - Register a, b and ctrl into `alu_a`/`alu_b`/`alu_ctrl`.
  - Record the owner and update `last_grant`.
  - Load the EXEC counter: L = `MULDIV_LAT` for 010/011, else L = 1.
  - Go to EXEC.
- **Divide-by-zero** (ctrl = 011, b = 0):
  - `alu_a`, `alu_b` and `alu_ctrl` are NOT updated; they keep their previous values.
  - L = 1.
  - Capture forces `rsp_result` = 16'hFFFF, `rsp_hi` = a (operand latched internally), `rsp_err` = 1.
- **EXEC:**
  - ALU operand registers are held constant.
  - Counter decrements each cycle. On the last EXEC cycle, capture and go to DONE.
- **Capture:**
  - `rsp_result` = `alu_result`.
  - `rsp_hi` = `alu_overflow` for mul/div; 16'h0000 for all other opcodes.
  - `rsp_err` = 0 except on divide-by-zero.
- **Arithmetic** (the ALU performs it; the controller does not alter it):
  - add/sub wrap modulo 2^16.
  - mul: result = product[15:0], hi = product[31:16].
  - div: unsigned; result = quotient, hi = remainder.
  - 110/111: result = 0, hi = 0.
- **DONE:**
  - The owner's `rspN_valid` = 1; the other response valid stays 0.
  - Response fields hold steady until `rspN_ready` = 1. On that cycle go to IDLE.
  - `rspN_ready` on the non-owner port is ignored.
- **Reset:**
  - Reset, including mid-EXEC or mid-DONE, aborts the transaction with no response.
  - All outputs go to 0: `rsp_*`, `alu_*`, `busy`, valids, `last_grant` = 1.
- **Request stability:** requesters hold a/b/ctrl stable while valid and not ready. The controller samples them only on the accept cycle.

## Timing

- Accept at cycle T; EXEC spans T+1 … T+L; `rspN_valid` is high from T+L+1.
- Add/sub/and/or/zero/div-by-zero: response at T+2. Mul/div: response at T+1+`MULDIV_LAT`.
- Response handshake at cycle R → IDLE at R+1; earliest next accept is R+1.
- Peak throughput for single-cycle ops: 1 op per 3 cycles.
- `alu_a`/`alu_b`/`alu_ctrl` change only on the cycle after an accept edge, never during EXEC or DONE.
- `busy` = 1 from T+1 through R inclusive.
- A requester whose valid drops before its grant is not served; no state is retained for it.

## Test plan

1. **Reset then add:** reset, then req0 add a = 16'hFFFF, b = 16'h0002. Expect `rsp0_valid` at T+2, result = 16'h0001, hi = 0, err = 0, `rsp1_valid` = 0 throughout.
2. **Mul latency** (`MULDIV_LAT` = 4): req1 mul a = 16'h1234, b = 16'h0100. Expect `rsp1_valid` at T+5, result = 16'h3400, hi = 16'h0012; `alu_a`/`alu_b` stable T+1..T+5.
3. **Divide-by-zero:** req0 div a = 16'h00AB, b = 0. Expect response at T+2, result = 16'hFFFF, hi = 16'h00AB, err = 1; `alu_b` unchanged from the prior op.
4. **Contention:** both valid continuously after reset. Grants alternate 0,1,0,1; never both ready; each request is served exactly once. Div 100/7 on req1 yields result 14, hi 2.
5. **Backpressure:** hold `rsp0_ready` = 0 for 10 cycles. Response fields stay constant, no new accept occurs, `busy` = 1; release → IDLE next cycle.
6. **Reset mid-EXEC:** reset during mul EXEC. All outputs are 0 next cycle, no response is emitted, and the next tie grants requester 0.
